// File: rtl/alu_seq.sv
// alu_seq: sequencing controller driving ALU op/enable, register-file addresses and the branch program counter
module alu_seq #(
  parameter int PCW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [15:0]    instr,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic           o_flag,
  input  logic           z_flag,
  input  logic           n_flag,
  output logic [2:0]     alu_op,
  output logic           alu_en,
  output logic [2:0]     ra_addr,
  output logic [2:0]     rb_addr,
  output logic [2:0]     wr_addr,
  output logic           wr_en,
  output logic [PCW-1:0] pc,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, EXEC, WB, BR} state_t;
  state_t         state;
  logic [3:0]     opc;
  logic [2:0]     rd;
  logic [7:0]     off;
  logic           take;
  logic [PCW-1:0] pc_inc;
  logic [PCW-1:0] pc_br;
  assign instr_ready = state == IDLE;
  assign busy        = ~instr_ready;
  // branch condition from live flags and both PC candidates; NOP/illegal never take
  always_comb begin
    take   = opc == 4'd8  ? z_flag :
             opc == 4'd9  ? n_flag :
             opc == 4'd10 ? o_flag :
             opc == 4'd11;
    pc_inc = pc + PCW'(1);
    pc_br  = pc + PCW'($signed(off));
  end
  // FSM with registered control outputs; reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      opc     <= '0;
      rd      <= '0;
      off     <= '0;
      pc      <= '0;
      alu_op  <= '0;
      ra_addr <= '0;
      rb_addr <= '0;
      wr_addr <= '0;
      alu_en  <= 1'b0;
      wr_en   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (instr_valid) begin
          opc <= instr[15:12];
          rd  <= instr[11:9];
          off <= instr[7:0];
          if (!instr[15]) begin
            state   <= EXEC;
            alu_en  <= 1'b1;
            alu_op  <= instr[14:12];
            ra_addr <= instr[8:6];
            rb_addr <= instr[5:3];
          end else begin
            state <= BR;
          end
        end
        EXEC: begin
          state   <= WB;
          alu_en  <= 1'b0;
          wr_en   <= 1'b1;
          wr_addr <= rd;
        end
        WB: begin
          state <= IDLE;
          wr_en <= 1'b0;
          pc    <= pc_inc;
        end
        BR: begin
          state <= IDLE;
          pc    <= take ? pc_br : pc_inc;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
